// File: rtl/pb_pkg.sv
// Shared constants and helpers for the multi-channel pushbutton conditioner.
// Buttons are active-low: PB_PRESSED is the electrical level of a held button.
package pb_pkg;

  localparam logic PB_PRESSED = 1'b0;
  localparam logic PB_IDLE    = 1'b1;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_CYCLES   = 4;
  localparam int DEF_LONG_CYCLES = 1000000;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pb_channel.sv
// One button channel: synchroniser, counter debounce, press/release strobes.
// Define PB_LONG_PRESS_EN to add the per-channel long-press hold counter.
module pb_channel
  import pb_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic PB,
  output logic level,
  output logic pressed,
  output logic released,
  output logic long_press
);

  localparam int            CW      = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_pressed;
  logic                   r_released;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Synchroniser resets to idle so an idle button never looks like a press.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], PB};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_level    <= PB_IDLE;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      if (w_sync_out == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_cnt      <= '0;
        r_level    <= w_sync_out;
        r_pressed  <= (w_sync_out == PB_PRESSED);
        r_released <= (w_sync_out == PB_IDLE);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level    = r_level;
  assign pressed  = r_pressed;
  assign released = r_released;

`ifdef PB_LONG_PRESS_EN
  localparam int            LW       = cnt_width(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_PRE = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] r_hold;
  logic          r_long;

  // Saturation at LONG_MAX is what limits the strobe to once per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (r_level == PB_IDLE) begin
        r_hold <= '0;
      end else if (r_hold != LONG_MAX) begin
        r_hold <= r_hold + LW'(1);
        r_long <= (r_hold == LONG_PRE);
      end
    end
  end

  assign long_press = r_long;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/pb_debounce_multi.sv
// Multi-channel pushbutton conditioner: N_CH independent pb_channel instances.
// Long-press strobes exist only when PB_LONG_PRESS_EN is defined.
module pb_debounce_multi
  import pb_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] PB,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pressed,
  output logic [N_CH-1:0] released,
  output logic [N_CH-1:0] long_press
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pb_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .PB        (PB[g]),
      .level     (level[g]),
      .pressed   (pressed[g]),
      .released  (released[g]),
      .long_press(long_press[g])
    );
  end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Directed bench for pb_debounce_multi (N_CH=2, SYNC=2, DB=4, LONG=10).
// Long-press expectations follow PB_LONG_PRESS_EN.
module tb_pb_debounce_multi;

  logic       clk;
  logic       rst;
  logic [1:0] PB;
  logic [1:0] level;
  logic [1:0] pressed;
  logic [1:0] released;
  logic [1:0] long_press;

  int total = 0;
  int bad   = 0;

  // Per-channel event record, edges numbered from 1 after each clear_rec.
  int e;
  int p_cnt[2], r_cnt[2], l_cnt[2];
  int p_edge[2], r_edge[2], l_edge[2];
  int fall_edge[2];
  int both_cnt = 0;

`ifdef PB_LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  pb_debounce_multi #(
    .N_CH(2), .SYNC_STAGES(2), .DB_CYCLES(4), .LONG_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .PB(PB), .level(level),
    .pressed(pressed), .released(released), .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_rec();
    e = 0;
    for (int c = 0; c < 2; c++) begin
      p_cnt[c] = 0; r_cnt[c] = 0; l_cnt[c] = 0;
      p_edge[c] = 0; r_edge[c] = 0; l_edge[c] = 0; fall_edge[c] = 0;
    end
  endtask

  task automatic step_rec(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      e++;
      for (int c = 0; c < 2; c++) begin
        if (pressed[c] === 1'b1) begin
          p_cnt[c]++;
          if (p_edge[c] == 0) p_edge[c] = e;
        end
        if (released[c] === 1'b1) begin
          r_cnt[c]++;
          if (r_edge[c] == 0) r_edge[c] = e;
        end
        if (long_press[c] === 1'b1) begin
          l_cnt[c]++;
          if (l_edge[c] == 0) l_edge[c] = e;
        end
        if (level[c] === 1'b0 && fall_edge[c] == 0) fall_edge[c] = e;
        if (pressed[c] === 1'b1 && released[c] === 1'b1) both_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    PB  = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (level !== 2'b11) begin
      bad++; $display("FAIL reset_level got=%b exp=%b", level, 2'b11);
    end
    rst = 1'b0;
    clear_rec();
    step_rec(20);
    total++;
    if (p_cnt[0] + p_cnt[1] + r_cnt[0] + r_cnt[1] + l_cnt[0] + l_cnt[1] != 0) begin
      bad++; $display("FAIL reset_strobes got=%0d exp=0",
                      p_cnt[0] + p_cnt[1] + r_cnt[0] + r_cnt[1] + l_cnt[0] + l_cnt[1]);
    end
    total++;
    if (level !== 2'b11) begin
      bad++; $display("FAIL reset_idle_level got=%b exp=%b", level, 2'b11);
    end
  endtask

  task automatic test_press();
    PB = 2'b10;
    clear_rec();
    step_rec(8);
    total++;
    if (p_cnt[0] != 1 || p_edge[0] != 6) begin
      bad++; $display("FAIL press_strobe got=cnt%0d@%0d exp=cnt1@6", p_cnt[0], p_edge[0]);
    end
    total++;
    if (fall_edge[0] != 6) begin
      bad++; $display("FAIL press_level_edge got=%0d exp=6", fall_edge[0]);
    end
    total++;
    if (r_cnt[0] != 0 || p_cnt[1] != 0 || r_cnt[1] != 0 || level !== 2'b10) begin
      bad++; $display("FAIL press_isolation got=r0:%0d p1:%0d r1:%0d lvl:%b exp=0 0 0 10",
                      r_cnt[0], p_cnt[1], r_cnt[1], level);
    end
    PB = 2'b11;
    clear_rec();
    step_rec(10);
    total++;
    if (r_cnt[0] != 1 || r_edge[0] != 6 || p_cnt[0] != 0) begin
      bad++; $display("FAIL release_strobe got=cnt%0d@%0d p%0d exp=cnt1@6 p0",
                      r_cnt[0], r_edge[0], p_cnt[0]);
    end
    total++;
    if (l_cnt[0] != 0 || level !== 2'b11) begin
      bad++; $display("FAIL release_long_level got=l%0d lvl%b exp=l0 lvl11", l_cnt[0], level);
    end
  endtask

  task automatic test_glitch();
    clear_rec();
    PB = 2'b10;
    step_rec(3);
    PB = 2'b11;
    step_rec(12);
    total++;
    if (p_cnt[0] != 0 || r_cnt[0] != 0 || fall_edge[0] != 0) begin
      bad++; $display("FAIL glitch_reject got=p%0d r%0d fall%0d exp=0 0 0",
                      p_cnt[0], r_cnt[0], fall_edge[0]);
    end
  endtask

  task automatic test_bounce();
    clear_rec();
    for (int t = 0; t < 5; t++) begin
      PB[1] = (t % 2 == 0) ? 1'b0 : 1'b1;
      step_rec(2);
    end
    PB[1] = 1'b0;
    step_rec(20);
    total++;
    if (p_cnt[1] != 1 || p_edge[1] != 14 || r_cnt[1] != 0) begin
      bad++; $display("FAIL bounce_press got=cnt%0d@%0d r%0d exp=cnt1@14 r0",
                      p_cnt[1], p_edge[1], r_cnt[1]);
    end
    total++;
    if (l_cnt[1] != (LONG_ON ? 1 : 0) || l_edge[1] != (LONG_ON ? 24 : 0)) begin
      bad++; $display("FAIL bounce_long got=cnt%0d@%0d exp=cnt%0d@%0d",
                      l_cnt[1], l_edge[1], LONG_ON ? 1 : 0, LONG_ON ? 24 : 0);
    end
    PB[1] = 1'b1;
    clear_rec();
    step_rec(10);
    total++;
    if (r_cnt[1] != 1 || r_edge[1] != 6 || p_cnt[1] != 0 || l_cnt[1] != 0) begin
      bad++; $display("FAIL bounce_release got=cnt%0d@%0d p%0d l%0d exp=cnt1@6 p0 l0",
                      r_cnt[1], r_edge[1], p_cnt[1], l_cnt[1]);
    end
  endtask

  task automatic test_simultaneous();
    PB = 2'b10;
    clear_rec();
    step_rec(8);
    total++;
    if (p_cnt[0] != 1 || level !== 2'b10) begin
      bad++; $display("FAIL simul_settle got=p%0d lvl%b exp=p1 lvl10", p_cnt[0], level);
    end
    PB = 2'b01;
    clear_rec();
    step_rec(8);
    total++;
    if (r_cnt[0] != 1 || r_edge[0] != 6 || p_cnt[1] != 1 || p_edge[1] != 6) begin
      bad++; $display("FAIL simul_swap got=r0@%0d x%0d p1@%0d x%0d exp=@6 x1 @6 x1",
                      r_edge[0], r_cnt[0], p_edge[1], p_cnt[1]);
    end
    total++;
    if (level !== 2'b01 || l_cnt[0] + l_cnt[1] != 0) begin
      bad++; $display("FAIL simul_level got=%b l%0d exp=01 l0", level, l_cnt[0] + l_cnt[1]);
    end
    PB = 2'b11;
    clear_rec();
    step_rec(10);
    total++;
    if (r_cnt[1] != 1 || level !== 2'b11 || l_cnt[1] != 0) begin
      bad++; $display("FAIL simul_idle got=r%0d lvl%b l%0d exp=r1 lvl11 l0",
                      r_cnt[1], level, l_cnt[1]);
    end
  endtask

  task automatic test_reset_mid();
    PB = 2'b10;
    clear_rec();
    step_rec(4);
    rst = 1'b1;
    #1;
    total++;
    if (level !== 2'b11 || pressed !== 2'b00 || released !== 2'b00) begin
      bad++; $display("FAIL rst_assert got=lvl%b p%b r%b exp=lvl11 p00 r00",
                      level, pressed, released);
    end
    step_rec(2);
    total++;
    if (p_cnt[0] + r_cnt[0] + l_cnt[0] != 0 || fall_edge[0] != 0) begin
      bad++; $display("FAIL rst_mid_no_strobe got=%0d fall%0d exp=0 0",
                      p_cnt[0] + r_cnt[0] + l_cnt[0], fall_edge[0]);
    end
    rst = 1'b0;
    clear_rec();
    step_rec(20);
    total++;
    if (p_cnt[0] != 1 || p_edge[0] != 6) begin
      bad++; $display("FAIL rst_repress got=cnt%0d@%0d exp=cnt1@6", p_cnt[0], p_edge[0]);
    end
    total++;
    if (l_cnt[0] != (LONG_ON ? 1 : 0) || l_edge[0] != (LONG_ON ? 16 : 0)) begin
      bad++; $display("FAIL rst_long got=cnt%0d@%0d exp=cnt%0d@%0d",
                      l_cnt[0], l_edge[0], LONG_ON ? 1 : 0, LONG_ON ? 16 : 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    PB  = 2'b11;
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    total++;
    if (both_cnt != 0) begin
      bad++; $display("FAIL both_strobes got=%0d exp=0", both_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
